hazard_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage MIPS core. Reads the destination and

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage MIPS core: operand forwarding,
// load-use and HI/LO interlocks, branch flush, mult/div occupancy, sticky
// halt and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    id_r1_pos,
    input  logic [4:0]    id_r2_pos,
    input  logic          id_uses_r1,
    input  logic          id_uses_r2,
    input  logic          id_uses_hilo,
    input  logic [4:0]    ex_r1_pos,
    input  logic [4:0]    ex_r2_pos,
    input  logic [4:0]    ex_dst,
    input  logic          ex_memread,
    input  logic          ex_md_start,
    input  logic          ex_branch,
    input  logic          ex_halt,
    input  logic [4:0]    mem_dst,
    input  logic          mem_regwrite,
    input  logic [4:0]    wb_dst,
    input  logic          wb_regwrite,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          if_id_clr,
    output logic          id_ex_en,
    output logic          id_ex_clr,
    output logic          ex_mem_en,
    output logic          mem_wb_en,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          md_busy,
    output logic [CW-1:0] stall_cnt
);

    localparam int unsigned MDW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [MDW-1:0] md_cnt;
    logic [MDW-1:0] md_cnt_nx;

    logic           load_use;
    logic           hilo_stall;
    logic [1:0]     fwd_a_raw;
    logic [1:0]     fwd_b_raw;

    // Hazard detection and forwarding selects; EX/MEM result is the youngest so it wins.
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_r1_pos)) begin
            fwd_a_raw = 2'b01;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_r1_pos)) begin
            fwd_a_raw = 2'b10;
        end
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_r2_pos)) begin
            fwd_b_raw = 2'b01;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_r2_pos)) begin
            fwd_b_raw = 2'b10;
        end
        load_use   = ex_memread && (ex_dst != 5'd0) &&
                     ((id_uses_r1 && (id_r1_pos == ex_dst)) ||
                      (id_uses_r2 && (id_r2_pos == ex_dst)));
        hilo_stall = md_busy && id_uses_hilo;
    end

    // Pipeline enables/bubbles: reset and halt freeze everything, branch flush beats stalls.
    always_comb begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_en  = 1'b0;
        id_ex_clr = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        if (rst_n && (state != HALT)) begin
            fwd_a     = fwd_a_raw;
            fwd_b     = fwd_b_raw;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_branch) begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end else if (load_use || hilo_stall) begin
                id_ex_clr = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    // Next-state: mult/div occupancy countdown and sticky halt (squashed by a taken branch).
    always_comb begin
        state_nx  = state;
        md_cnt_nx = md_cnt;
        case (state)
            RUN: begin
                if (ex_md_start) begin
                    state_nx  = MD_BUSY;
                    md_cnt_nx = MDW'(MD_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (md_cnt == '0) begin
                    state_nx = RUN;
                end else begin
                    md_cnt_nx = md_cnt - MDW'(1);
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        if (ex_halt && !ex_branch) begin
            state_nx = HALT;
        end
    end

    // State and mult/div counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    assign md_busy = (state == MD_BUSY);

    // Saturating count of cycles the PC was held while not halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state != HALT) && !pc_en && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MD_LAT=4, CW=4).
module tb_hazard_ctrl;

    localparam int unsigned MD_LAT = 4;
    localparam int unsigned CW     = 4;

    // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en, md_busy}
    localparam logic [7:0] C_NORM  = 8'b1101_0110;
    localparam logic [7:0] C_BUSY  = 8'b1101_0111;
    localparam logic [7:0] C_STALL = 8'b0001_1110;
    localparam logic [7:0] C_STLB  = 8'b0001_1111;
    localparam logic [7:0] C_FLUSH = 8'b1111_1110;
    localparam logic [7:0] C_OFF   = 8'b0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_r1_pos, id_r2_pos, ex_r1_pos, ex_r2_pos, ex_dst, mem_dst, wb_dst;
    logic          id_uses_r1, id_uses_r2, id_uses_hilo;
    logic          ex_memread, ex_md_start, ex_branch, ex_halt, mem_regwrite, wb_regwrite;
    logic          pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en;
    logic [1:0]    fwd_a, fwd_b;
    logic          md_busy;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
        .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2), .id_uses_hilo(id_uses_hilo),
        .ex_r1_pos(ex_r1_pos), .ex_r2_pos(ex_r2_pos), .ex_dst(ex_dst),
        .ex_memread(ex_memread), .ex_md_start(ex_md_start), .ex_branch(ex_branch),
        .ex_halt(ex_halt), .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
        .id_ex_en(id_ex_en), .id_ex_clr(id_ex_clr), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs_ctl();
        return {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en, md_busy};
    endfunction

    task automatic clear_in();
        id_r1_pos = '0; id_r2_pos = '0; ex_r1_pos = '0; ex_r2_pos = '0;
        ex_dst = '0; mem_dst = '0; wb_dst = '0;
        id_uses_r1 = 0; id_uses_r2 = 0; id_uses_hilo = 0;
        ex_memread = 0; ex_md_start = 0; ex_branch = 0; ex_halt = 0;
        mem_regwrite = 0; wb_regwrite = 0;
    endtask

    // Inputs already applied: queue the expectation, then compare at the falling edge.
    task automatic cyc(input string tag, input logic [7:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [3:0] cnt);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_ctl"}, 16'(obs_ctl()), 16'(e.ctl));
            check_eq({e.tag, "_fwd"}, 16'({fwd_a, fwd_b}), 16'({e.fa, e.fb}));
            check_eq({e.tag, "_cnt"}, 16'(stall_cnt), 16'(e.cnt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        clear_in();
        rst_n = 1'b0;
        #2;
        check_eq("rst_ctl", 16'(obs_ctl()), 16'(C_OFF));
        check_eq("rst_fwd", 16'({fwd_a, fwd_b}), 16'd0);
        check_eq("rst_cnt", 16'(stall_cnt), 16'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding
        mem_dst = 5; mem_regwrite = 1; wb_dst = 5; wb_regwrite = 1; ex_r1_pos = 5; ex_r2_pos = 5;
        cyc("fwd_mem", C_NORM, 2'b01, 2'b01, 4'd0);
        mem_regwrite = 0;
        cyc("fwd_wb", C_NORM, 2'b10, 2'b10, 4'd0);
        mem_regwrite = 1; mem_dst = 0; wb_dst = 0; ex_r1_pos = 0; ex_r2_pos = 0;
        cyc("fwd_r0", C_NORM, 2'b00, 2'b00, 4'd0);
        mem_dst = 5; wb_dst = 7; ex_r1_pos = 5; ex_r2_pos = 7;
        cyc("fwd_mix", C_NORM, 2'b01, 2'b10, 4'd0);
        clear_in();

        // Load-use
        ex_memread = 1; ex_dst = 8; id_uses_r2 = 1; id_r2_pos = 8;
        cyc("lu", C_STALL, 2'b00, 2'b00, 4'd0);
        clear_in();
        cyc("lu_after", C_NORM, 2'b00, 2'b00, 4'd1);
        ex_memread = 1; ex_dst = 0; id_uses_r1 = 1; id_r1_pos = 0;
        cyc("lu_r0", C_NORM, 2'b00, 2'b00, 4'd1);
        clear_in();

        // Branch beats load-use
        ex_memread = 1; ex_dst = 8; id_uses_r2 = 1; id_r2_pos = 8; ex_branch = 1;
        cyc("lu_br", C_FLUSH, 2'b00, 2'b00, 4'd1);
        clear_in();
        cyc("lu_br_after", C_NORM, 2'b00, 2'b00, 4'd1);

        // Mult/div with HI/LO consumer waiting
        ex_md_start = 1;
        cyc("md_issue", C_NORM, 2'b00, 2'b00, 4'd1);
        ex_md_start = 0; id_uses_hilo = 1;
        for (int i = 0; i < 4; i++) cyc("md_stall", C_STLB, 2'b00, 2'b00, 4'(1 + i));
        cyc("md_done", C_NORM, 2'b00, 2'b00, 4'd5);
        clear_in();

        // Mult/div without consumer
        ex_md_start = 1;
        cyc("md2_issue", C_NORM, 2'b00, 2'b00, 4'd5);
        ex_md_start = 0;
        for (int i = 0; i < 4; i++) cyc("md2_busy", C_BUSY, 2'b00, 2'b00, 4'd5);
        cyc("md2_done", C_NORM, 2'b00, 2'b00, 4'd5);

        // Saturation
        ex_memread = 1; ex_dst = 8; id_uses_r1 = 1; id_r1_pos = 8;
        for (int i = 0; i < 20; i++) begin
            exp_cnt = (5 + i > 15) ? 15 : 5 + i;
            cyc("sat", C_STALL, 2'b00, 2'b00, 4'(exp_cnt));
        end
        clear_in();
        cyc("sat_end", C_NORM, 2'b00, 2'b00, 4'd15);

        // Halt squashed by branch, then real halt
        ex_halt = 1; ex_branch = 1;
        cyc("halt_sq", C_FLUSH, 2'b00, 2'b00, 4'd15);
        clear_in();
        cyc("halt_sq_after", C_NORM, 2'b00, 2'b00, 4'd15);
        ex_halt = 1;
        cyc("halt_issue", C_NORM, 2'b00, 2'b00, 4'd15);
        clear_in();
        ex_memread = 1; ex_dst = 8; id_uses_r1 = 1; id_r1_pos = 8;
        for (int i = 0; i < 12; i++) cyc("halted", C_OFF, 2'b00, 2'b00, 4'd15);
        clear_in();

        // Reset clears halt; then async reset mid mult/div
        rst_n = 1'b0;
        #1;
        check_eq("rst2_ctl", 16'(obs_ctl()), 16'(C_OFF));
        check_eq("rst2_cnt", 16'(stall_cnt), 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst", C_NORM, 2'b00, 2'b00, 4'd0);
        ex_md_start = 1;
        cyc("md3_issue", C_NORM, 2'b00, 2'b00, 4'd0);
        ex_md_start = 0;
        #2;
        check_eq("md3_busy", 16'(md_busy), 16'd1);
        rst_n = 1'b0;
        #1;
        check_eq("md3_rst_busy", 16'(md_busy), 16'd0);
        check_eq("md3_rst_ctl", 16'(obs_ctl()), 16'(C_OFF));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("md3_after", C_NORM, 2'b00, 2'b00, 4'd0);

        check_eq("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
